// File: rtl/add8_seq_ctrl.sv
// Byte-serial (8*NBYTES)-bit adder controller: drives one external 8-bit adder
// a byte per clock, LSB first, chaining the carry through a register.
module add8_seq_ctrl #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_s,
    input  logic         add_cout,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic [1:0]   state_dbg
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic                    carry_q, carry_d;
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;
    logic                    cout_q, cout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                // The previous result stays visible until a new operation is accepted.
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = add_s;
                carry_d      = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        sum       = sum_q;
        cout      = cout_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Bench for add8_seq_ctrl: NBYTES=4 instance under a queued scoreboard and an
// NBYTES=1 instance checked directly; both paired with a behavioural 8-bit adder.
module tb_add8_seq_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NBYTES=4 instance
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic         cin = 1'b0;
    logic [7:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic [1:0]   state_dbg;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);

    add8_seq_ctrl #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
        .add_cout(add_cout), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .state_dbg(state_dbg)
    );

    // NBYTES=1 instance
    logic       start1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic [7:0] add_a1, add_b1, add_s1, sum1;
    logic       add_cin1, add_cout1, busy1, done1, cout1;
    logic [1:0] state_dbg1;

    assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + 9'(add_cin1);

    add8_seq_ctrl #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1),
        .add_cout(add_cout1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .state_dbg(state_dbg1)
    );

    // scoreboard state
    int errors = 0;
    int checks = 0;
    int n_ops = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic [W:0]  exp_q[$];
    logic [16:0] byte_q[$];
    logic [W:0]  last_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference: {cout,sum} = a + b + cin; byte i sees carry = bit 8i of the low-part sum
    task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        logic [63:0] m, part;
        r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        exp_q.push_back(r);
        last_exp = r;
        n_ops++;
        for (int i = 0; i < NB; i++) begin
            m = (64'd1 << (8 * i)) - 64'd1;
            part = ((64'(a) & m) + (64'(b) & m) + 64'(c)) >> (8 * i);
            byte_q.push_back({a[8*i +: 8], b[8*i +: 8], part[0]});
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, cnt);
        end
    endtask

    // issue one operation; with hold=1 start stays high afterwards
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit hold);
        wait_idle();
        chk("idle_result_hold", 64'({cout, sum}), 64'(last_exp));
        a_in = a;
        b_in = b;
        cin = c;
        start = 1'b1;
        push_expect(a, b, c);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + 9'(c);
        @(negedge clk);
        a1 = a;
        b1 = b;
        cin1 = c;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_busy_c1", 64'({busy1, done1}), 64'(2'b10));
        chk("n1_add_bytes", 64'({add_a1, add_b1, add_cin1}), 64'({a, b, c}));
        @(negedge clk);
        chk("n1_done_c2", 64'({busy1, done1}), 64'(2'b11));
        chk("n1_result", 64'({cout1, sum1}), 64'(r));
        @(negedge clk);
        chk("n1_idle", 64'({busy1, done1}), 64'(2'b00));
    endtask

    // monitor: adder-port sequence, busy length, result pops
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !done) begin
                if (busy_cnt == 0)
                    chk("run_entry_cleared", 64'({cout, sum}), 64'd0);
                if (byte_q.size() == 0) begin
                    chk("unexpected_run_byte", 64'({add_a, add_b, add_cin}), 64'd0);
                end else begin
                    chk("adder_port_byte", 64'({add_a, add_b, add_cin}), 64'(byte_q.pop_front()));
                end
            end else begin
                chk("adder_port_quiet", 64'({add_a, add_b, add_cin}), 64'd0);
            end
            if (done) begin
                done_cnt++;
                chk("busy_cycles_at_done", 64'(busy_cnt + 1), 64'(NB + 1));
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'({cout, sum}), 64'd0);
                    checks--;
                    errors++;
                    checks++;
                end else begin
                    chk("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
                end
            end
            busy_cnt = busy ? busy_cnt + 1 : 0;
        end else begin
            busy_cnt = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({busy, done, cout, sum}), 64'd0);
        chk("rst_adder_port", 64'({add_a, add_b, add_cin}), 64'd0);
        chk("rst_n1_outputs", 64'({busy1, done1, cout1, sum1, add_a1, add_b1, add_cin1}), 64'd0);
        #2 rst = 1'b0;

        // directed cases
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        do_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0);

        // start while busy must be ignored
        do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        a_in = 32'h1234_5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // reset in the middle of RUN
        do_op(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", 64'({busy, done, cout, sum}), 64'd0);
        exp_q.delete();
        byte_q.delete();
        last_exp = '0;
        n_ops--;
        @(negedge clk);
        #2 rst = 1'b0;
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

        // random, sometimes with start held high into the next operation
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 32'hFFFF_FFFF; rb = $urandom; end
                1: begin ra = $urandom; rb = ~ra; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), (i != 39) && ($urandom_range(0, 1) == 1));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        // NBYTES=1 build
        op1(8'hFF, 8'h01, 1'b0);
        op1(8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) op1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        chk("pending_results", 64'(exp_q.size()), 64'd0);
        chk("done_pulse_count", 64'(done_cnt), 64'(n_ops));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
